// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the IDLE/WAIT request bus. The master state machine
// and the memory-side responder both import this package, so the state
// encodings on either side of the bus always agree.
//   BUS_IDLE / BUS_WAIT : master state encodings
//   slave_state_e       : responder FSM states (same encoding as the master)
//   bus_req_t           : one latched request (wen, addr, wdata, wmask)
//   CNT_W               : latency counter width (LATENCY up to 15)
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam logic BUS_IDLE = 1'b0;
  localparam logic BUS_WAIT = 1'b1;

  // Responder states reuse the master encoding so both sides can be compared
  // directly when the two are run together.
  typedef enum logic {
    SLV_IDLE = BUS_IDLE,
    SLV_WAIT = BUS_WAIT
  } slave_state_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_req_t;

  localparam int unsigned CNT_W = 4;

endpackage : bus_pkg

// File: rtl/bus_mem_slave_if.sv
// -----------------------------------------------------------------------------
// bus_mem_slave_if
// Request/response bundle between the bus master state machine and the
// memory responder.
//   reqValid  : request present (master -> slave)
//   reqWen    : 1 = write, 0 = read
//   reqAddr   : byte address, bits [1:0] ignored
//   reqWdata  : write data
//   reqWmask  : byte-lane write enables
//   respValid : one-cycle response pulse (slave -> master)
//   respRdata : read data, 0 outside the response cycle
//   respErr   : address out of range, only meaningful with respValid
//   busy      : slave holds an accepted request
// -----------------------------------------------------------------------------
interface bus_mem_slave_if;

  logic        reqValid;
  logic        reqWen;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqWmask;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respErr;
  logic        busy;

  modport master (
    output reqValid, reqWen, reqAddr, reqWdata, reqWmask,
    input  respValid, respRdata, respErr, busy
  );

  modport slave (
    input  reqValid, reqWen, reqAddr, reqWdata, reqWmask,
    output respValid, respRdata, respErr, busy
  );

endinterface : bus_mem_slave_if

// File: rtl/bus_mem_array.sv
// -----------------------------------------------------------------------------
// bus_mem_array
// DEPTH_WORDS x 32-bit backing store with one asynchronous read port and one
// synchronous byte-masked write port.
//   clock    : write clock, rising edge
//   i_we     : write enable
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_wmask  : byte-lane enables, bit i covers [8i+7:8i]
//   i_raddr  : read word index
//   o_rdata  : read data (combinational from the array)
// -----------------------------------------------------------------------------
module bus_mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wmask,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // NOTE: the storage has no reset on purpose; a reset branch here would
  // stop synthesis from mapping it onto a RAM macro and cost a mux per bit.
  always_ff @(posedge clock) begin
    if (i_we) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (i_wmask[lane]) begin
          r_mem[i_waddr][8*lane +: 8] <= i_wdata[8*lane +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : bus_mem_array

// File: rtl/bus_mem_slave.sv
// -----------------------------------------------------------------------------
// bus_mem_slave
// Memory-side responder for the IDLE/WAIT request bus. Accepts one request,
// holds it for LATENCY cycles, then performs the read or byte-masked write and
// returns a one-cycle respValid pulse. Only one transaction is ever
// outstanding; requests seen while WAITing are ignored.
//   clock : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : bus_mem_slave_if.slave (request in, response/busy out)
// Parameters:
//   DEPTH_WORDS : words in the backing array (power of two)
//   LATENCY     : cycles from request sample to respValid (1..15)
//   BASE_ADDR   : byte address of word 0
// -----------------------------------------------------------------------------
module bus_mem_slave
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic            clock,
  input  logic            reset,
  bus_mem_slave_if.slave  bus
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;

  slave_state_e     r_state;
  slave_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  bus_req_t         r_req;
  bus_req_t         w_req_nxt;

  logic [31:0]      w_off;
  logic             w_err;
  logic [AW-1:0]    w_idx;
  logic             w_resp;
  logic             w_we;
  logic [31:0]      w_rdata;

  // ---------------------------------------------------------------------------
  // Range check on the latched address. The subtraction wraps for addresses
  // below BASE_ADDR, which the explicit compare catches even when the wrapped
  // offset would alias into the array.
  // ---------------------------------------------------------------------------
  assign w_off = r_req.addr - BASE_ADDR;
  assign w_err = (r_req.addr < BASE_ADDR) || (w_off >= SPAN_BYTES);
  assign w_idx = w_off[AW+1:2];

  // The response cycle is the last WAIT cycle; everything below is decoded
  // from registers so no req* input reaches a resp* output combinationally.
  assign w_resp = (r_state == SLV_WAIT) && (r_cnt == '0);
  assign w_we   = w_resp && r_req.wen && !w_err;

  // ---------------------------------------------------------------------------
  // Next-state / request latch
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value before the case; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    case (r_state)
      SLV_IDLE: begin
        if (bus.reqValid) begin
          w_req_nxt   = '{wen:   bus.reqWen,
                          addr:  bus.reqAddr,
                          wdata: bus.reqWdata,
                          wmask: bus.reqWmask};
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = SLV_WAIT;
        end
      end
      SLV_WAIT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_state_nxt = SLV_IDLE;
        end
      end
      default: w_state_nxt = SLV_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SLV_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Backing store. The write commits at the edge ending the response cycle;
  // reset forces IDLE asynchronously, which drops any pending write.
  // ---------------------------------------------------------------------------
  bus_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clock   (clock),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (r_req.wdata),
    .i_wmask (r_req.wmask),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.respValid = w_resp;
  assign bus.respErr   = w_resp && w_err;
  assign bus.respRdata = (w_resp && !r_req.wen && !w_err) ? w_rdata : 32'h0;
  assign bus.busy      = (r_state == SLV_WAIT);

endmodule : bus_mem_slave

// File: tb/tb_bus_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_slave
// Directed bench for bus_mem_slave. Two instances share clock and reset:
// u_l2 (LATENCY=2) for functional/range/reset cases and a randomised master
// run, u_l1 (LATENCY=1) for the back-to-back and ignore-in-WAIT case.
// Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_bus_mem_slave;
  import bus_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  bus_mem_slave_if if_l2 ();
  bus_mem_slave_if if_l1 ();

  bus_mem_slave #(
    .DEPTH_WORDS (1024),
    .LATENCY     (2),
    .BASE_ADDR   (32'h8000_0000)
  ) u_l2 (
    .clock (clock),
    .reset (reset),
    .bus   (if_l2)
  );

  bus_mem_slave #(
    .DEPTH_WORDS (1024),
    .LATENCY     (1),
    .BASE_ADDR   (32'h8000_0000)
  ) u_l1 (
    .clock (clock),
    .reset (reset),
    .bus   (if_l1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic        s_v, s_e, s_b;
  logic [31:0] s_rd;

  // Randomised master run state
  logic        m_state;
  int          mism, acc_cnt, resp_cnt;
  logic        p_wen;
  int unsigned p_idx;
  logic [31:0] p_wdata;
  logic [3:0]  p_mask;
  logic [31:0] ref_mem [8];
  logic        known   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask);
    if (sel) begin
      if_l1.reqValid = v;    if_l1.reqWen   = wen;  if_l1.reqAddr = addr;
      if_l1.reqWdata = wdata; if_l1.reqWmask = mask;
    end else begin
      if_l2.reqValid = v;    if_l2.reqWen   = wen;  if_l2.reqAddr = addr;
      if_l2.reqWdata = wdata; if_l2.reqWmask = mask;
    end
  endtask

  task automatic sample(input bit sel, output logic v, output logic [31:0] rd,
                        output logic e, output logic b);
    if (sel) begin
      v = if_l1.respValid; rd = if_l1.respRdata; e = if_l1.respErr; b = if_l1.busy;
    end else begin
      v = if_l2.respValid; rd = if_l2.respRdata; e = if_l2.respErr; b = if_l2.busy;
    end
  endtask

  // One complete transaction: request in cycle T, wait (bounded) for
  // respValid, check latency/data/err, then check the pulse ends.
  task automatic xact(input bit sel, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] exp_rd, input logic exp_err, input string tag);
    logic v, e, b;
    logic [31:0] rd;
    int lat;
    @(negedge clock);
    drive(sel, 1'b1, wen, addr, wdata, mask);
    @(negedge clock);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    lat = 1;
    sample(sel, v, rd, e, b);
    check({tag, ".busy"}, {31'b0, b}, 32'd1);
    while (v !== 1'b1 && lat < 16) begin
      @(negedge clock);
      lat++;
      sample(sel, v, rd, e, b);
    end
    check({tag, ".lat"}, lat, sel ? 32'd1 : 32'd2);
    check({tag, ".rdata"}, rd, exp_rd);
    check({tag, ".err"}, {31'b0, e}, {31'b0, exp_err});
    @(negedge clock);
    sample(sel, v, rd, e, b);
    check({tag, ".pulse_end"}, {31'b0, v}, 32'd0);
    check({tag, ".idle"}, {31'b0, b}, 32'd0);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state on both instances
    @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      sample(s[0], s_v, s_rd, s_e, s_b);
      check($sformatf("reset.v%0d", s),  {31'b0, s_v}, 32'd0);
      check($sformatf("reset.rd%0d", s), s_rd,         32'd0);
      check($sformatf("reset.e%0d", s),  {31'b0, s_e}, 32'd0);
      check($sformatf("reset.b%0d", s),  {31'b0, s_b}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;

    // Basic read (preload word 0 through the bus)
    xact(0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, "pre0");
    xact(0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, "rd0");

    // Masked write: lanes 0 and 2 only
    xact(0, 1'b1, 32'h8000_0004, 32'h1122_3344, 4'hF,    32'h0,         1'b0, "pre1");
    xact(0, 1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0101, 32'h0,         1'b0, "mwr1");
    xact(0, 1'b0, 32'h8000_0004, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0, "rd1");
    // Zero-mask write is a normal no-op; low address bits ignored
    xact(0, 1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 4'h0,    32'h0,         1'b0, "nomask");
    xact(0, 1'b0, 32'h8000_0007, 32'h0,         4'h0,    32'h11BB_33DD, 1'b0, "rd1b");

    // Range boundaries: last word is in range, neighbours on both sides are not
    xact(0, 1'b1, 32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0, "last_wr");
    xact(0, 1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1, "oor_rd");
    xact(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, "oor_wr_hi");
    xact(0, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, "oor_wr_lo");
    xact(0, 1'b0, 32'h8000_0000, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, "keep0");
    xact(0, 1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 32'h0BAD_F00D, 1'b0, "keep_last");

    // Reset in the cycle after a write is accepted
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF);
    @(negedge clock);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    sample(0, s_v, s_rd, s_e, s_b);
    check("rst_mid.busy_before", {31'b0, s_b}, 32'd1);
    reset = 1'b0;
    #1;
    sample(0, s_v, s_rd, s_e, s_b);
    check("rst_mid.v",    {31'b0, s_v}, 32'd0);
    check("rst_mid.busy", {31'b0, s_b}, 32'd0);
    check("rst_mid.rd",   s_rd,         32'd0);
    @(negedge clock);
    reset = 1'b1;
    xact(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, "rst_mid.read");

    // Back-to-back on LATENCY=1 with reqValid held high and the address
    // stepping every cycle: only words 0, 2, 4 are accepted.
    for (int k = 0; k < 5; k++) begin
      xact(1, 1'b1, 32'h8000_0000 + 32'(4 * k), 32'hA0A0_0000 + 32'(k), 4'hF,
           32'h0, 1'b0, $sformatf("l1pre%0d", k));
    end
    @(negedge clock);
    drive(1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      sample(1, s_v, s_rd, s_e, s_b);
      check($sformatf("b2b.v%0d", k), {31'b0, s_v}, (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 1) begin
        check($sformatf("b2b.rd%0d", k), s_rd, 32'hA0A0_0000 + 32'(k - 1));
      end
      drive(1, (k <= 4) ? 1'b1 : 1'b0, 1'b0, 32'h8000_0000 + 32'(4 * k), 32'h0, 4'h0);
    end
    @(negedge clock);
    sample(1, s_v, s_rd, s_e, s_b);
    check("b2b.idle", {31'b0, s_b}, 32'd0);

    // Randomised master on LATENCY=2: states must track, one response per request
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 32'h0;
      known[i]   = 1'b0;
    end
    ref_mem[0] = 32'hDEAD_BEEF; known[0] = 1'b1;
    ref_mem[1] = 32'h11BB_33DD; known[1] = 1'b1;
    m_state = BUS_IDLE;
    mism = 0; acc_cnt = 0; resp_cnt = 0;
    p_wen = 1'b0; p_idx = 0; p_wdata = 32'h0; p_mask = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      sample(0, s_v, s_rd, s_e, s_b);
      if (s_b !== (m_state == BUS_WAIT)) mism++;
      if (s_v === 1'b1) begin
        resp_cnt++;
        if (m_state != BUS_WAIT) mism++;
        if (s_e !== 1'b0) mism++;
        if (p_wen) begin
          if (s_rd !== 32'h0) mism++;
          for (int l = 0; l < 4; l++) begin
            if (p_mask[l]) ref_mem[p_idx][8*l +: 8] = p_wdata[8*l +: 8];
          end
          if (p_mask == 4'hF) known[p_idx] = 1'b1;
        end else if (known[p_idx] && s_rd !== ref_mem[p_idx]) begin
          mism++;
        end
        m_state = BUS_IDLE;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end else if (m_state == BUS_IDLE && c < 2990 && $urandom_range(0, 2) != 0) begin
        p_wen   = 1'($urandom_range(0, 1));
        p_idx   = $urandom_range(0, 7);
        p_wdata = $urandom;
        p_mask  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
        drive(0, 1'b1, p_wen, 32'h8000_0000 + 32'(4 * p_idx), p_wdata, p_mask);
        m_state = BUS_WAIT;
        acc_cnt++;
      end else begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    check("rand.mismatches", mism, 32'd0);
    check("rand.resp_count", resp_cnt, acc_cnt);
    check("rand.final_busy", {31'b0, if_l2.busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bus_mem_slave
